// File: rtl/conv_pkg.sv
// Shared types and size helpers for the convolution scheduler.
// Latency: none (package only).
// Backpressure: none (package only).
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_F,
        FEED,
        WAIT,
        WRITE,
        DONE
    } state_t;

    localparam int FLT_DEFAULT = 4;

    // Number of valid window positions along the width.
    function automatic int out_w(input int img_w, input int flt);
        return img_w - flt + 1;
    endfunction

    // Number of valid window positions along the height.
    function automatic int out_h(input int img_h, input int flt);
        return img_h - flt + 1;
    endfunction

endpackage

// File: rtl/window_counter.sv
// 2-D counter: inner index steps fastest, outer advances when inner wraps.
// Latency: counts update one cycle after en; clr takes priority over en.
// Backpressure: none; en simply holds the count when low.
module window_counter #(
    parameter int W       = 8,
    parameter int OUT_MAX = 3,
    parameter int IN_MAX  = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] outer,
    output logic [W-1:0] inner,
    output logic         last
);

    localparam logic [W-1:0] OUT_LAST = W'(OUT_MAX);
    localparam logic [W-1:0] IN_LAST  = W'(IN_MAX);

    // Step inner, carry into outer, wrap both to zero after the last position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outer <= '0;
            inner <= '0;
        end else if (clr) begin
            outer <= '0;
            inner <= '0;
        end else if (en) begin
            if (inner == IN_LAST) begin
                inner <= '0;
                outer <= (outer == OUT_LAST) ? '0 : outer + 1'b1;
            end else begin
                inner <= inner + 1'b1;
            end
        end
    end

    assign last = (outer == OUT_LAST) && (inner == IN_LAST);

endmodule

// File: rtl/conv_scheduler.sv
// Sequences filter load, per-window picture feed, MAC wait and result write for a 2-D convolution.
// Latency: FLT*FLT load cycles, then FLT*FLT+WAIT+1 cycles per window, then one done cycle.
// Backpressure: WAIT stalls indefinitely on mac_done; abort returns to IDLE on the next edge.
module conv_scheduler
    import conv_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int FLT   = FLT_DEFAULT,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          mac_done,
    output logic          filter_read,
    output logic          filter_write,
    output logic          pic_read,
    output logic [AW-1:0] pic_addr,
    output logic [1:0]    i_filter,
    output logic [1:0]    j_filter,
    output logic          mac_start,
    output logic          res_we,
    output logic [AW-1:0] res_addr,
    output logic          busy,
    output logic          done
);

    localparam int OUT_W = out_w(IMG_W, FLT);
    localparam int OUT_H = out_h(IMG_H, FLT);

    // Reject parameter sets the address width or 2-bit filter indices cannot cover.
    if (IMG_W * IMG_H > (2 ** AW)) begin : g_bad_aw
        $error("conv_scheduler: IMG_W*IMG_H exceeds 2**AW");
    end
    if (FLT < 1 || FLT > 4 || FLT > IMG_W || FLT > IMG_H) begin : g_bad_flt
        $error("conv_scheduler: FLT must be 1..4 and fit inside the picture");
    end

    state_t        state;
    logic          f_last;
    logic          p_last;
    logic          cnt_clr;
    logic          f_en;
    logic          p_en;
    logic [AW-1:0] row;
    logic [AW-1:0] col;
    logic [AW-1:0] pic_row;
    logic [AW-1:0] pic_col;

    // Both counters are held at zero while idle and flushed on abort.
    assign cnt_clr = (state == IDLE) || abort;
    assign f_en    = (state == LOAD_F) || (state == FEED);
    assign p_en    = (state == WRITE);

    window_counter #(
        .W       (2),
        .OUT_MAX (FLT - 1),
        .IN_MAX  (FLT - 1)
    ) u_filt_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (f_en),
        .outer (i_filter),
        .inner (j_filter),
        .last  (f_last)
    );

    window_counter #(
        .W       (AW),
        .OUT_MAX (OUT_H - 1),
        .IN_MAX  (OUT_W - 1)
    ) u_pos_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (p_en),
        .outer (row),
        .inner (col),
        .last  (p_last)
    );

    // Pass sequencing; abort overrides every other transition, including mac_done in WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start)    state <= LOAD_F;
                LOAD_F:  if (f_last)   state <= FEED;
                FEED:    if (f_last)   state <= WAIT;
                WAIT:    if (mac_done) state <= WRITE;
                WRITE:   state <= p_last ? DONE : FEED;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Moore strobes; counters sit at zero in IDLE so both addresses decode to zero there.
    assign filter_read  = (state == LOAD_F);
    assign filter_write = (state == LOAD_F);
    assign pic_read     = (state == FEED);
    assign mac_start    = (state == FEED) && (i_filter == 2'd0) && (j_filter == 2'd0);
    assign res_we       = (state == WRITE);
    assign done         = (state == DONE);
    assign busy         = (state != IDLE);

    assign pic_row  = row + AW'(i_filter);
    assign pic_col  = col + AW'(j_filter);
    assign pic_addr = pic_row * AW'(IMG_W) + pic_col;
    assign res_addr = row * AW'(OUT_W) + col;

endmodule

// File: doc/conv_scheduler.md
CONV_SCHEDULER -- requirements
Module: conv_scheduler

Interface
REQ-001 Parameter IMG_W, default 8: picture width in pixels.
REQ-002 Parameter IMG_H, default 8: picture height in pixels.
REQ-003 Parameter FLT, default 4: square filter side; the filter index outputs are 2 bits wide.
REQ-004 Parameter AW, default 8: address width; IMG_W*IMG_H SHALL be at most 2^AW (elaboration-time check).
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  request a full convolution pass; sampled only in IDLE.
REQ-008 abort  in  1  synchronous abort; returns the FSM to IDLE.
REQ-009 mac_done  in  1  MAC finished the current window; sampled only in WAIT.
REQ-010 filter_read  out  1  filter memory read enable.
REQ-011 filter_write  out  1  write the current filter word into filter register [i_filter][j_filter].
REQ-012 pic_read  out  1  picture memory read enable.
REQ-013 pic_addr  out  AW  picture address = (row+i_filter)*IMG_W + (col+j_filter).
REQ-014 i_filter, j_filter  out  2 each  filter row/column index.
REQ-015 mac_start  out  1  one-cycle pulse; clears the MAC accumulator and begins a window.
REQ-016 res_we  out  1  result write strobe.
REQ-017 res_addr  out  AW  result address = row*OUT_W + col, where OUT_W = IMG_W-FLT+1 and OUT_H = IMG_H-FLT+1.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 done  out  1  one-cycle pulse at pass completion.

Function
REQ-020 The FSM SHALL have exactly the states IDLE, LOAD_F, FEED, WAIT, WRITE, DONE.
REQ-021 IDLE: when start=1, the next state SHALL be LOAD_F, and row, col, i_filter and j_filter SHALL clear to 0.
REQ-022 LOAD_F SHALL last FLT*FLT cycles, with filter_read=filter_write=1 and (i_filter,j_filter) stepping j-major from (0,0) to (FLT-1,FLT-1); the next state SHALL be FEED.
REQ-023 FEED SHALL last FLT*FLT cycles, with pic_read=1 and the filter indices stepping as in LOAD_F.
REQ-024 mac_start SHALL be high only in the first FEED cycle of each window; the next state SHALL be WAIT.
REQ-025 WAIT SHALL hold until mac_done=1, then go to WRITE.
REQ-026 mac_done seen in any state other than WAIT SHALL be ignored; WAIT SHALL have no timeout.
REQ-027 WRITE SHALL last one cycle with res_we=1 and res_addr for the current (row,col).
REQ-028 On leaving WRITE: if col<OUT_W-1 then col+1 and go to FEED.
REQ-029 On leaving WRITE: else if row<OUT_H-1 then col=0, row+1 and go to FEED.
REQ-030 On leaving WRITE: else go to DONE.
REQ-031 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-032 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-033 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with no done and no res_we; abort SHALL win over mac_done in the same cycle.
REQ-034 All strobes (filter_read, filter_write, pic_read, mac_start, res_we, done) SHALL be Moore outputs decoded from state and counters.
REQ-035 All strobes SHALL be 0 in IDLE, and pic_addr, res_addr and the filter indices SHALL be 0 in IDLE.
REQ-036 Address arithmetic SHALL be unsigned and computed at AW bits with no wrap for legal parameters.

Reset
REQ-037 rst=1 SHALL immediately force IDLE, clear row, col, i_filter and j_filter, and drive every output to 0, independent of clk.
REQ-038 After rst deasserts, the first start SHALL be accepted on the first clk edge at which it is high.

Structure
REQ-039 A shared package conv_pkg SHALL hold the state enum, the FLT default, and the OUT_W/OUT_H derivation functions.
REQ-040 One sub-module, window_counter, SHALL implement a 2-D counter with clear, enable, wrap and last flag; it SHALL be instantiated once for (row,col) and once for the filter indices.

Verification
REQ-041 8x8 picture, FLT=4, mac_done returned on the first WAIT cycle, start pulsed -> 16 filter_write, 25 mac_start, 25 res_we at res_addr 0..24 in order, done exactly 467 cycles after the start edge.
REQ-042 First window -> the pic_addr sequence is 0,1,2,3,8,9,10,11,16,...,27; for row=4, col=4 the last pic_addr is 63.
REQ-043 mac_done delayed 5 cycles in every window -> WAIT lasts 5 cycles, total time 567 cycles, and mac_done pulses injected during FEED produce no early WRITE.
REQ-044 abort during WAIT of window 10, with mac_done in the same cycle -> IDLE next cycle, no res_we for window 10, no done, and busy=0.
REQ-045 rst asserted mid-FEED between clock edges -> all outputs 0 before the next edge, and a new start runs a full pass correctly.
REQ-046 start held high across an entire pass -> exactly one pass per IDLE visit, with the next pass beginning the cycle after done.
